// File: rtl/err_recovery_accum.sv
// Sequential error-recovery accumulator: folds NVEC per-row-pair error vectors
// into the exact correction term C = sum_k E_k << (2+2k), one vector per cycle.
module err_recovery_accum #(
  parameter int VW        = 16,
  parameter int NVEC      = 8,
  parameter bit SKIP_ZERO = 1'b1,
  // Derived widths; keep the defaults unless VW/NVEC change.
  parameter int CW        = VW + 2*NVEC + 1,
  parameter int NW        = $clog2(NVEC + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [VW*NVEC-1:0] err_vec,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CW-1:0]      corr,
  output logic [NW-1:0]      nnz,
  output logic               err_any
);

  localparam int IW = (NVEC > 1) ? $clog2(NVEC) : 1;
  localparam int SW = IW + 2;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t               state_reg;
  logic [VW*NVEC-1:0]   vecs_reg;
  logic [IW-1:0]        idx_reg;
  logic [CW-1:0]        acc_reg;

  logic [VW-1:0]        vec_arr [NVEC];
  logic [NVEC-1:0]      nz_mask;
  logic [NVEC-1:0]      in_nz;

  logic [IW-1:0]        first_idx;
  logic [IW-1:0]        next_idx;
  logic                 next_found;
  logic [NW-1:0]        in_cnt;
  logic [VW-1:0]        vec_sel;
  logic [SW-1:0]        shamt;
  logic [CW-1:0]        addend;
  logic [CW-1:0]        acc_sum;
  logic                 accum_last;

  genvar gi;
  generate
    for (gi = 0; gi < NVEC; gi++) begin : g_vec
      assign vec_arr[gi] = vecs_reg[gi*VW +: VW];
      assign nz_mask[gi] = |vec_arr[gi];
      assign in_nz[gi]   = |err_vec[gi*VW +: VW];
    end
  endgenerate

  // Priority scans: lowest nonzero vector of the incoming word, and the next
  // nonzero captured vector strictly above the current index.
  always_comb begin
    first_idx  = '0;
    next_idx   = '0;
    next_found = 1'b0;
    in_cnt     = '0;
    for (int k = NVEC - 1; k >= 0; k--) begin
      if (in_nz[k]) begin
        first_idx = IW'(k);
      end
      if (nz_mask[k] && (IW'(k) > idx_reg)) begin
        next_idx   = IW'(k);
        next_found = 1'b1;
      end
    end
    for (int k = 0; k < NVEC; k++) begin
      in_cnt = in_cnt + NW'(in_nz[k]);
    end
  end

  assign vec_sel = vec_arr[idx_reg];
  assign shamt   = {1'b0, idx_reg, 1'b0} + SW'(2);
  assign addend  = CW'(vec_sel) << shamt;
  assign acc_sum = acc_reg + addend;

  assign accum_last = SKIP_ZERO ? !next_found : (idx_reg == IW'(NVEC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      vecs_reg  <= '0;
      idx_reg   <= '0;
      acc_reg   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      corr      <= '0;
      nnz       <= '0;
      err_any   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            vecs_reg  <= err_vec;
            acc_reg   <= '0;
            nnz       <= in_cnt;
            err_any   <= |in_nz;
            idx_reg   <= SKIP_ZERO ? first_idx : '0;
            in_ready  <= 1'b0;
            state_reg <= ACCUM;
          end
        end
        ACCUM: begin
          acc_reg <= acc_sum;
          if (accum_last) begin
            corr      <= acc_sum;
            out_valid <= 1'b1;
            state_reg <= DONE;
          end else begin
            idx_reg <= SKIP_ZERO ? next_idx : (idx_reg + IW'(1));
          end
        end
        DONE: begin
          // Result is held until the consumer takes it; no new accept here.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_err_recovery_accum.sv
// Self-checking bench: skip-zero and fixed-schedule instances share stimulus
// and are compared against an arithmetic model of the correction term.
module tb_err_recovery_accum;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] err_vec = '0;

  logic         in_ready1, out_valid1, err_any1;
  logic [32:0]  corr1;
  logic [3:0]   nnz1;
  logic         in_ready0, out_valid0, err_any0;
  logic [32:0]  corr0;
  logic [3:0]   nnz0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  err_recovery_accum #(.VW(16), .NVEC(8), .SKIP_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .err_vec(err_vec), .out_valid(out_valid1), .out_ready(out_ready),
    .corr(corr1), .nnz(nnz1), .err_any(err_any1)
  );

  err_recovery_accum #(.VW(16), .NVEC(8), .SKIP_ZERO(1'b0)) dut_fixed (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .err_vec(err_vec), .out_valid(out_valid0), .out_ready(out_ready),
    .corr(corr0), .nnz(nnz0), .err_any(err_any0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: C = sum_k E_k * 4^(k+1)
  function automatic logic [63:0] model_corr(input logic [127:0] v);
    logic [63:0] sum;
    logic [63:0] w;
    sum = 0;
    w   = 64'd4;
    for (int k = 0; k < 8; k++) begin
      sum = sum + 64'(v[k*16 +: 16]) * w;
      w   = w * 64'd4;
    end
    return sum;
  endfunction

  function automatic int model_nnz(input logic [127:0] v);
    int n;
    n = 0;
    for (int k = 0; k < 8; k++) if (v[k*16 +: 16] != 16'h0) n++;
    return n;
  endfunction

  task automatic run_op(input logic [127:0] v, input logic [63:0] ec, input int en,
                        input logic ea, input int el, input string tag);
    int g1;
    int g0;
    @(negedge clk);
    check({tag, "_in_ready"}, {62'd0, in_ready1, in_ready0}, 64'd3);
    err_vec   = v;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    err_vec  = {$urandom, $urandom, $urandom, $urandom};
    g1 = -1;
    g0 = -1;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (out_valid1 && g1 < 0) begin
        g1 = c;
        check({tag, "_corr"}, 64'(corr1), ec);
        check({tag, "_nnz"}, 64'(nnz1), 64'(en));
        check({tag, "_err_any"}, 64'(err_any1), 64'(ea));
      end
      if (out_valid0 && g0 < 0) begin
        g0 = c;
        check({tag, "_corr_fixed"}, 64'(corr0), ec);
        check({tag, "_nnz_fixed"}, 64'(nnz0), 64'(en));
      end
    end
    check({tag, "_latency"}, 64'(g1), 64'(el));
    check({tag, "_latency_fixed"}, 64'(g0), 64'd8);
    $display("op %s: vec=0x%032h corr=0x%0h nnz=%0d lat=%0d/%0d", tag, v, corr1, nnz1, g1, g0);
  endtask

  typedef struct {
    logic [127:0] vec;
    logic [32:0]  corr;
    int           nnz;
    logic         err_any;
    int           lat;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] v;
    logic [63:0]  ec;
    int           n;
    int           stray;

    tbl[0] = '{128'h1,                             33'h0_0000_0004, 1, 1'b1, 1};
    tbl[1] = '{{16'hFFFF, 112'h0},                 33'h0_FFFF_0000, 1, 1'b1, 1};
    tbl[2] = '{{8{16'hFFFF}},                      33'h1_5552_AAAC, 8, 1'b1, 8};
    tbl[3] = '{128'h0,                             33'h0,           0, 1'b0, 1};
    tbl[4] = '{{64'h0, 16'h8000, 48'h0},           33'h0_0080_0000, 1, 1'b1, 1};
    tbl[5] = '{{96'h0, 16'h0001, 16'h0001},        33'h0_0000_0014, 2, 1'b1, 2};
    tbl[6] = '{{112'h0, 16'hFFFF},                 33'h0_0003_FFFC, 1, 1'b1, 1};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid1), 64'd0);
    check("rst_corr", 64'(corr1), 64'd0);
    check("rst_nnz", 64'(nnz1), 64'd0);
    check("rst_err_any", 64'(err_any1), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready1), 64'd1);

    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].vec, 64'(tbl[i].corr), tbl[i].nnz, tbl[i].err_any, tbl[i].lat,
             $sformatf("tbl%0d", i));
    end

    // Backpressure in DONE with a stray in_valid pulse
    v  = {80'h0, 16'h0F0F, 16'h0};
    ec = model_corr(v);
    @(negedge clk);
    err_vec  = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 20 && !(out_valid1 && out_valid0); c++) @(negedge clk);
    check("bp_reach_done", {62'd0, out_valid1, out_valid0}, 64'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i == 2);
      err_vec  = {$urandom, $urandom, $urandom, $urandom};
      check($sformatf("bp_out_valid%0d", i), 64'(out_valid1), 64'd1);
      check($sformatf("bp_corr%0d", i), 64'(corr1), ec);
      check($sformatf("bp_in_ready%0d", i), {62'd0, in_ready1, in_ready0}, 64'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_retire_out_valid", 64'(out_valid1), 64'd0);
    check("bp_retire_in_ready", 64'(in_ready1), 64'd1);
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid1 || out_valid0) stray++;
    end
    check("bp_no_capture", 64'(stray), 64'd0);
    $display("op backpressure: corr=0x%0h stray=%0d", ec, stray);

    // Reset in the middle of ACCUM
    @(negedge clk);
    err_vec  = {64'h0, {4{16'h00FF}}};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {62'd0, out_valid1, out_valid0}, 64'd0);
    check("mid_rst_corr", 64'(corr1), 64'd0);
    check("mid_rst_nnz", 64'(nnz1), 64'd0);
    check("mid_rst_err_any", 64'(err_any1), 64'd0);
    check("mid_rst_nnz_fixed", 64'(nnz0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid1 || out_valid0) stray++;
    end
    check("mid_rst_no_result", 64'(stray), 64'd0);
    $display("op midreset: stray=%0d", stray);
    v = {80'h0, 16'h0003, 32'h0};
    run_op(v, model_corr(v), model_nnz(v), 1'b1, 1, "post_rst");

    // Randomized operations against the model
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 8; k++) begin
        case ($urandom_range(0, 3))
          0:       v[k*16 +: 16] = 16'h0;
          1:       v[k*16 +: 16] = 16'($urandom);
          2:       v[k*16 +: 16] = 16'h1 << $urandom_range(0, 15);
          default: v[k*16 +: 16] = 16'hFFFF;
        endcase
      end
      n = model_nnz(v);
      run_op(v, model_corr(v), n, (v != 128'h0), (n > 1) ? n : 1, $sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
